// File: rtl/usbh_pkg.sv
// Shared USB host definitions: CRC16 constants, checker FSM state and result payload.
package usbh_pkg;

  localparam int unsigned USBH_LEN_W = 11;

  localparam logic [15:0] USBH_CRC16_INIT      = 16'hFFFF;
  localparam logic [15:0] USBH_CRC16_RESIDUAL  = 16'hB001;
  // Polynomial 0x8005 in bit-reversed form, for an LSB-first register.
  localparam logic [15:0] USBH_CRC16_POLY_REFL = 16'hA001;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    CHECK = 2'd2
  } usbh_crc_chk_st_t;

  // Per-packet verdict reported alongside done_o.
  typedef struct packed {
    logic                  crc_err;
    logic                  len_err;
    logic [USBH_LEN_W-1:0] len;
  } usbh_rx_result_t;

endpackage

// File: rtl/usbh_crc16.sv
// Combinational USB CRC16 byte step (reflected register, data consumed LSB first).
module usbh_crc16
  import usbh_pkg::*;
(
  input  logic [15:0] crc_i,
  input  logic [7:0]  data_i,
  output logic [15:0] crc_o
);

  logic [15:0] crc_w;

  // Eight bit-serial steps unrolled into one cycle.
  always_comb begin
    crc_w = crc_i;
    for (int i = 0; i < 8; i++) begin
      if (crc_w[0] ^ data_i[i]) crc_w = (crc_w >> 1) ^ USBH_CRC16_POLY_REFL;
      else                      crc_w = crc_w >> 1;
    end
    crc_o = crc_w;
  end

endmodule

// File: rtl/usbh_rx_crc16_chk.sv
// Receive data-packet CRC16 checker: checks the residual over payload plus CRC bytes
// and reports pass/fail with the payload length.
// Build option USBH_RX_CRC_STRIP_EN: withhold the two trailing CRC bytes from the
// forwarded stream through a 2-byte delay line and exclude them from len_o.
module usbh_rx_crc16_chk
  import usbh_pkg::*;
#(
  parameter int unsigned MAX_LEN = 1023
)
(
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  start_i,
  input  logic                  rx_valid_i,
  input  logic [7:0]            rx_data_i,
  input  logic                  end_i,
  output logic                  data_valid_o,
  output logic [7:0]            data_o,
  output logic                  done_o,
  output logic                  crc_err_o,
  output logic                  len_err_o,
  output logic [USBH_LEN_W-1:0] len_o,
  output logic                  busy_o
);

  localparam int unsigned     CNT_W   = $clog2(MAX_LEN + 3);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LEN + 2);

  usbh_crc_chk_st_t state_q, state_d;

  logic [15:0]      crc_q, crc_d, crc_step;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  usbh_rx_result_t  res_q, res_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             dv_q, dv_d;
  logic [7:0]       dout_q, dout_d;

`ifdef USBH_RX_CRC_STRIP_EN
  logic [7:0]       dl0_q, dl0_d;
  logic [7:0]       dl1_q, dl1_d;
  logic [1:0]       occ_q, occ_d;
`endif

  logic in_byte;
  logic take;
  logic finish;

  // A restart always wins over the byte and end strobes of the same cycle.
  assign in_byte = (state_q == RUN) && rx_valid_i && !start_i;
  assign take    = in_byte && (cnt_q != CNT_MAX);
  assign finish  = (state_q == RUN) && end_i && !start_i;

  usbh_crc16 u_crc16 (
    .crc_i  (crc_q),
    .data_i (rx_data_i),
    .crc_o  (crc_step)
  );

  // FSM state register.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_i) state_d = RUN;
      RUN:     if (start_i) state_d = RUN;
               else if (end_i) state_d = CHECK;
      CHECK:   state_d = start_i ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output next values.
  always_comb begin
    crc_d  = crc_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    res_d  = res_q;
    done_d = 1'b0;
    busy_d = (state_d != IDLE);
    dv_d   = 1'b0;
    dout_d = dout_q;
`ifdef USBH_RX_CRC_STRIP_EN
    dl0_d  = dl0_q;
    dl1_d  = dl1_q;
    occ_d  = occ_q;
`endif
    if (start_i) begin
      crc_d = USBH_CRC16_INIT;
      cnt_d = '0;
      ovf_d = 1'b0;
      res_d = '0;
`ifdef USBH_RX_CRC_STRIP_EN
      dl0_d = '0;
      dl1_d = '0;
      occ_d = 2'd0;
`endif
    end else begin
      if (in_byte) crc_d = crc_step;
      if (take)    cnt_d = cnt_q + CNT_W'(1);
      if (in_byte && !take) ovf_d = 1'b1;
      if (take) begin
`ifdef USBH_RX_CRC_STRIP_EN
        // Emit the oldest byte only once two newer ones exist behind it.
        if (occ_q == 2'd2) begin
          dv_d   = 1'b1;
          dout_d = dl0_q;
        end else begin
          occ_d  = occ_q + 2'd1;
        end
        dl0_d = dl1_q;
        dl1_d = rx_data_i;
`else
        dv_d   = 1'b1;
        dout_d = rx_data_i;
`endif
      end
      // Verdict uses the post-update values so a byte on the end cycle is included.
      if (finish) begin
        done_d        = 1'b1;
        res_d.crc_err = (crc_d != USBH_CRC16_RESIDUAL) || (cnt_d < CNT_W'(2));
        res_d.len_err = ovf_d;
`ifdef USBH_RX_CRC_STRIP_EN
        res_d.len     = (cnt_d < CNT_W'(2)) ? '0 : USBH_LEN_W'(cnt_d - CNT_W'(2));
`else
        res_d.len     = USBH_LEN_W'(cnt_d);
`endif
      end
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      crc_q  <= USBH_CRC16_INIT;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      res_q  <= '0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
      dv_q   <= 1'b0;
      dout_q <= '0;
`ifdef USBH_RX_CRC_STRIP_EN
      dl0_q  <= '0;
      dl1_q  <= '0;
      occ_q  <= 2'd0;
`endif
    end else begin
      crc_q  <= crc_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
      res_q  <= res_d;
      done_q <= done_d;
      busy_q <= busy_d;
      dv_q   <= dv_d;
      dout_q <= dout_d;
`ifdef USBH_RX_CRC_STRIP_EN
      dl0_q  <= dl0_d;
      dl1_q  <= dl1_d;
      occ_q  <= occ_d;
`endif
    end
  end

  assign data_valid_o = dv_q;
  assign data_o       = dout_q;
  assign done_o       = done_q;
  assign crc_err_o    = res_q.crc_err;
  assign len_err_o    = res_q.len_err;
  assign len_o        = res_q.len;
  assign busy_o       = busy_q;

endmodule

// File: doc/usbh_rx_crc16_chk.md
# usbh_rx_crc16_chk

Receive-side USB data-packet checker. Sits between the SIE receive byte stream (after PID strip) and the host receive FIFO. Runs the USB CRC16 over every received byte including the two trailing CRC bytes, checks the residual, and reports a per-packet pass/fail with the payload length. Optionally withholds the two CRC bytes from the forwarded stream via a 2-byte delay line.

## Interface
- `MAX_LEN`, default 1023: maximum payload bytes per packet, excluding CRC. Length counter width is `$clog2(MAX_LEN+3)`.
- `clk_i`, in, 1: the block's one clock.
- `rstn_i`, in, 1: asynchronous, active-low reset.
- `start_i`, in, 1: pulse, first cycle of a new data packet (after PID).
- `rx_valid_i`, in, 1: `rx_data_i` holds a received byte this cycle.
- `rx_data_i`, in, 8: received byte, LSB first on the wire.
- `end_i`, in, 1: pulse at end of packet (EOP seen).
- `data_valid_o`, out, 1: forwarded payload byte strobe.
- `data_o`, out, 8: forwarded payload byte.
- `done_o`, out, 1: one-cycle packet-complete strobe.
- `crc_err_o`, out, 1: residual mismatch or short packet. Valid with `done_o`, held until the next `start_i`.
- `len_err_o`, out, 1: payload exceeded `MAX_LEN`. Valid with `done_o`.
- `len_o`, out, 11: payload byte count. Valid with `done_o`.
- `busy_o`, out, 1: the FSM is not in IDLE.

## Operation
- **FSM states:** IDLE, RUN, CHECK.
  - IDLE → RUN on `start_i`.
  - RUN → CHECK on `end_i`.
  - CHECK → IDLE unconditionally after one cycle.
- **CRC accumulator:**
  - Set to 0xFFFF on `start_i`.
  - On each `rx_valid_i` in RUN: `crc <= step(crc, rx_data_i)`, using the USB CRC16 byte step (poly 0x8005, reflected).
  - Packet is good when the accumulator equals 0xB001 in CHECK.
- **Byte counter:**
  - Cleared on `start_i`.
  - Increments per valid byte and saturates at `MAX_LEN+2`.
  - `len_o` = count − 2 when stripping is enabled (0 if count < 2); otherwise the raw count.
- **Short packet (count < 2):** `crc_err_o`=1.
- **Length overflow:** `len_err_o`=1 if count > `MAX_LEN+2`. Bytes beyond that are neither counted nor forwarded, but are still CRC'd.
- **Simultaneous events:**
  - `rx_valid_i` together with `end_i`: the byte is included.
  - `start_i` in RUN or CHECK: abort and restart. No `done_o` for the aborted packet. Accumulator, counter and delay line are reset.
  - `start_i` has priority over `end_i` in the same cycle.
- Bytes and `end_i` arriving in IDLE are ignored.
- **Reset values:** all outputs 0, FSM IDLE, accumulator 0xFFFF, counter 0. A reset mid-packet discards the packet silently.

## Timing
- `data_o` and `data_valid_o` are registered.
  - With stripping: input byte n (n ≥ 2, 0-based) causes output of byte n−2 on the following cycle.
  - Without stripping: each byte appears one cycle after input.
- `end_i` sampled at cycle t → `done_o`, `crc_err_o`, `len_err_o`, `len_o` valid at t+1.
- No backpressure: the downstream must accept one byte per cycle.
- Consecutive bytes may arrive on back-to-back cycles.

## Configuration
- **`USBH_RX_CRC_STRIP_EN` defined:**
  - 2-entry byte delay line with occupancy counter (0..2).
  - The last two bytes (CRC) are never forwarded.
  - `len_o` excludes the CRC bytes.
- **Undefined:**
  - No delay line; all bytes, including the CRC, are forwarded.
  - `len_o` counts all bytes.
  - `len_err_o` threshold becomes `MAX_LEN+2` raw bytes.
- CRC check behaviour is identical in both builds.

## Structure
- **Shared `usbh_pkg`:**
  - State enum `usbh_crc_chk_st_t` {IDLE, RUN, CHECK}.
  - `USBH_CRC16_INIT` = 16'hFFFF.
  - `USBH_CRC16_RESIDUAL` = 16'hB001.
- **Sub-module:** instantiate the existing combinational `usbh_crc16` byte-step block for the accumulator update. No other sub-modules.

## Test plan
- **Empty packet:** `start_i`, bytes 0x00 0x00, `end_i` → `done_o` at t+1, `crc_err_o`=0, `len_o`=0, no `data_valid_o` (strip build).
- **Valid payload:** payload 0x00 0x01 0x02 0x03 plus model-computed CRC bytes, back-to-back → `data_o` 00,01,02,03 each 1 cycle after input n+2, `crc_err_o`=0, `len_o`=4.
- **Corrupted payload:** same packet with bit 0 of byte 2 flipped → `crc_err_o`=1, `len_o`=4.
- **Short packets:**
  - Single byte 0x5A, then `end_i` → `crc_err_o`=1, `len_o`=0.
  - `end_i` with no bytes → `crc_err_o`=1.
- **Restart:** `start_i` mid-packet after 3 bytes, then a clean empty packet → exactly one `done_o`, `crc_err_o`=0.
- **Overflow and reset:**
  - `MAX_LEN`=8 with 10 payload bytes plus valid CRC → `len_err_o`=1, 8 bytes forwarded.
  - `rstn_i` low mid-packet → all outputs 0 asynchronously, FSM IDLE.
